// File: rtl/result_ram_streamer.sv
// rtl/result_ram_streamer.sv - streams the 64-word result RAM out over valid/ready (optional RESULT_CHECKSUM_EN)
module result_ram_streamer #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic [10:0]       cycle_count
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic signed [DATA_W+5:0] checksum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [1:0]        fifo_count;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic [DATA_W-1:0] data0, data1;
    logic [ADDR_W-1:0] idx0, idx1;
    logic              pop;
    logic              push;
    logic [2:0]        level;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = data0;
    assign out_index = idx0;
    assign out_last  = out_valid && (idx0 == ADDR_W'(DEPTH - 1));
    assign pop       = out_valid && out_ready;
    assign push      = inflight;

    // Occupancy the FIFO would have after this cycle's pop and the pending read land;
    // issuing only while it is at most 1 guarantees a slot for the new read.
    assign level     = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign ram_rd_en = !reset && (state == S_STREAM) && (level <= 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_addr      <= '0;
            fifo_count    <= 2'd0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            data0         <= '0;
            data1         <= '0;
            idx0          <= '0;
            idx1          <= '0;
            cycle_count   <= 11'd0;
`ifdef RESULT_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            inflight <= ram_rd_en;
            if (ram_rd_en)
                inflight_addr <= ram_addr;

            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        data0 <= ram_rdata;
                        idx0  <= inflight_addr;
                    end else begin
                        data1 <= ram_rdata;
                        idx1  <= inflight_addr;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    data0      <= data1;
                    idx0       <= idx1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        data0 <= ram_rdata;
                        idx0  <= inflight_addr;
                    end else begin
                        data0 <= data1;
                        idx0  <= idx1;
                        data1 <= ram_rdata;
                        idx1  <= inflight_addr;
                    end
                end
                default: ;
            endcase

            if (busy && cycle_count != 11'd2047)
                cycle_count <= cycle_count + 11'd1;

`ifdef RESULT_CHECKSUM_EN
            if (pop)
                checksum <= checksum + {{6{out_data[DATA_W-1]}}, out_data};
`endif

            case (state)
                S_IDLE: begin
                    ram_addr <= '0;
                    if (start) begin
                        state       <= S_STREAM;
                        busy        <= 1'b1;
                        cycle_count <= 11'd0;
`ifdef RESULT_CHECKSUM_EN
                        checksum    <= '0;
`endif
                    end
                end
                S_STREAM: begin
                    if (ram_rd_en) begin
                        if (ram_addr == ADDR_W'(DEPTH - 1))
                            state <= S_DRAIN;
                        else
                            ram_addr <= ram_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // The final word is always the last FIFO entry, so its handshake ends the run.
                    if (pop && out_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done     <= 1'b0;
                    ram_addr <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_ram_streamer.sv
// tb/tb_result_ram_streamer.sv - self-checking bench for result_ram_streamer
module tb_result_ram_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        ram_rd_en;
    logic [5:0]  ram_addr;
    logic [18:0] ram_rdata = '0;
    logic [18:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic        out_last;
    logic [10:0] cycle_count;
`ifdef RESULT_CHECKSUM_EN
    logic [24:0] checksum;
`endif

    result_ram_streamer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .cycle_count(cycle_count)
`ifdef RESULT_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic signed [18:0] mem [64];
    always_ff @(posedge clk)
        if (ram_rd_en) ram_rdata <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk = 0;
    int err = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        chk++;
        if (!ok) begin
            err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state, owned by the compare process
    int     exp_idx = 0, issued = 0, popped = 0, run_done = 0;
    int     t_start = 0, first_rd = -1, first_valid = -1, last_cyc = -1, done_cyc = -1;
    longint sum = 0;
    bit     held = 0;
    logic [18:0] held_data;
    logic [5:0]  held_idx;

    always @(negedge clk) begin
        bit pop_now;
        if (reset) begin
            exp_idx = 0; issued = 0; popped = 0; held = 0; sum = 0;
        end else begin
            pop_now = out_valid && out_ready;
            if (start && !busy && !done) begin
                t_start = cyc; exp_idx = 0; issued = 0; popped = 0; run_done = 0;
                first_rd = -1; first_valid = -1; last_cyc = -1; done_cyc = -1; sum = 0;
            end
            if (held) begin
                check(out_valid == 1'b1, "held_valid", longint'(out_valid), 1);
                check(out_data == held_data, "held_data", longint'($signed(out_data)), longint'($signed(held_data)));
                check(out_index == held_idx, "held_index", longint'(out_index), longint'(held_idx));
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            held_idx = out_index;
            if (ram_rd_en) begin
                check(issued - popped - int'(pop_now) <= 1, "rd_fifo_room", issued - popped - int'(pop_now), 1);
                check(int'(ram_addr) == issued, "ram_addr", longint'(ram_addr), issued);
                if (issued == 0) first_rd = cyc;
                issued++;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (pop_now) begin
                if (exp_idx < 64) begin
                    check(longint'($signed(out_data)) == longint'(mem[exp_idx]), "out_data",
                          longint'($signed(out_data)), longint'(mem[exp_idx]));
                    check(int'(out_index) == exp_idx, "out_index", longint'(out_index), exp_idx);
                    check(out_last == (exp_idx == 63), "out_last", longint'(out_last), longint'(exp_idx == 63));
                    sum += longint'(mem[exp_idx]);
                end else begin
                    check(0, "extra_word", exp_idx, 63);
                end
                if (out_last) last_cyc = cyc;
                exp_idx++;
                popped++;
            end
            if (done) begin
                run_done++;
                done_cyc = cyc;
                check(exp_idx == 64, "words_at_done", exp_idx, 64);
`ifdef RESULT_CHECKSUM_EN
                check(longint'($signed(checksum)) == sum, "checksum_model", longint'($signed(checksum)), sum);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (run_done == 0 && n < limit) begin
            tick();
            n++;
        end
        check(run_done != 0, "done_timeout", n, limit);
        repeat (3) tick();
    endtask

    task automatic wait_word(input int idx);
        int n = 0;
        while (!(out_valid && int'(out_index) == idx) && n < 200) begin
            tick();
            n++;
        end
        check(n < 200, "word_timeout", n, 200);
    endtask

    task automatic load_ramp(input int offset);
        for (int i = 0; i < 64; i++) mem[i] = 19'(i + offset);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        load_ramp(-32);
        repeat (3) tick();
        check(busy == 0 && done == 0 && ram_rd_en == 0, "reset_ctrl", {busy, done, ram_rd_en}, 0);
        check(ram_addr == 0 && out_index == 0, "reset_addr", ram_addr, 0);
        check(out_valid == 0 && out_last == 0 && out_data == 0, "reset_out", out_data, 0);
        check(cycle_count == 0, "reset_cycle_count", cycle_count, 0);
        reset = 1'b0;
        tick();

        // Ramp -32..31, consumer always ready
        out_ready = 1'b1;
        pulse_start();
        wait_done(200);
        check(run_done == 1, "t1_done_pulses", run_done, 1);
        check(popped == 64, "t1_words", popped, 64);
        check(first_rd - t_start == 1, "t1_first_rd", first_rd - t_start, 1);
        check(first_valid - t_start == 3, "t1_first_valid", first_valid - t_start, 3);
        check(last_cyc - t_start == 66, "t1_last_word", last_cyc - t_start, 66);
        check(done_cyc - t_start == 67, "t1_done_time", done_cyc - t_start, 67);
        check(cycle_count == 11'd66, "t1_cycle_count", cycle_count, 66);
        check(busy == 0 && done == 0, "t1_idle_after", {busy, done}, 0);

        // Backpressure for 5 cycles while word 10 is presented
        pulse_start();
        wait_word(10);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check(longint'($signed(out_data)) == -22, "t2_word10_data", longint'($signed(out_data)), -22);
            check(out_index == 6'd10 && out_valid, "t2_word10_index", out_index, 10);
            tick();
        end
        out_ready = 1'b1;
        wait_done(200);
        check(popped == 64, "t2_words", popped, 64);
        check(cycle_count == 11'd71, "t2_cycle_count", cycle_count, 71);

        // Signed extremes with random backpressure
        for (int i = 0; i < 64; i++) mem[i] = (i % 2 == 1) ? 19'sd262143 : -19'sd262144;
        pulse_start();
        begin
            int n = 0;
            while (run_done == 0 && n < 2000) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            check(run_done != 0, "t3_timeout", n, 2000);
        end
        out_ready = 1'b1;
        repeat (3) tick();
        check(popped == 64, "t3_words", popped, 64);

        // Start re-pulsed mid-run is ignored
        load_ramp(-32);
        pulse_start();
        wait_word(20);
        pulse_start();
        wait_done(200);
        check(run_done == 1, "t4_done_pulses", run_done, 1);
        check(popped == 64, "t4_words", popped, 64);
        check(cycle_count == 11'd66, "t4_cycle_count", cycle_count, 66);

        // Reset mid-run, then a fresh run
        pulse_start();
        wait_word(30);
        reset = 1'b1;
        tick();
        check(busy == 0 && done == 0 && ram_rd_en == 0, "t5_reset_ctrl", {busy, done, ram_rd_en}, 0);
        check(ram_addr == 0 && out_index == 0 && out_data == 0, "t5_reset_addr", ram_addr, 0);
        check(out_valid == 0 && out_last == 0, "t5_reset_valid", out_valid, 0);
        check(cycle_count == 0, "t5_reset_cycle_count", cycle_count, 0);
        reset = 1'b0;
        tick();
        pulse_start();
        wait_done(200);
        check(run_done == 1, "t5_done_pulses", run_done, 1);
        check(popped == 64, "t5_words", popped, 64);
        check(cycle_count == 11'd66, "t5_cycle_count", cycle_count, 66);

`ifdef RESULT_CHECKSUM_EN
        load_ramp(0);
        pulse_start();
        wait_done(200);
        check(longint'($signed(checksum)) == 2016, "t6_checksum_ramp", longint'($signed(checksum)), 2016);
        for (int i = 0; i < 64; i++) mem[i] = -19'sd262144;
        pulse_start();
        wait_done(200);
        check(longint'($signed(checksum)) == -16777216, "t6_checksum_min",
              longint'($signed(checksum)), -16777216);
`endif

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/result_ram_streamer.md
Name: result_ram_streamer

Overview:
Reader side of the matrix-multiply result memory. The MAC datapath writes the 8x8 product matrix into the output RAM. This block reads all 64 entries back in address order and streams them out over a valid/ready interface, for a host or checker to consume. It absorbs the RAM's 1-cycle read latency and arbitrary consumer backpressure through a 2-entry output FIFO, with no lost or duplicated words.

Parameters:
DATA_W, 19, width of one result word (signed; matches the MAC accumulator width)
ADDR_W, 6, result RAM address width
DEPTH, 64, number of words streamed per run (2**ADDR_W for a full 8x8 matrix)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  1-cycle request to begin a readout; honoured only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  1-cycle pulse the cycle after the last word handshakes
ram_rd_en  output  1  RAM read strobe
ram_addr  output  ADDR_W  RAM read address
ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_rd_en
out_data  output  DATA_W  streamed result word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word this cycle
out_index  output  ADDR_W  RAM address that out_data came from
out_last  output  1  high with the final word (out_index == DEPTH-1)
cycle_count  output  11  cycles spent busy, held after done

Behaviour:
- Reset values: busy=0, done=0, ram_rd_en=0, ram_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, cycle_count=0. The FIFO is emptied and any in-flight read is discarded.
- FSM:
  - IDLE: start moves to STREAM and clears cycle_count.
  - STREAM: read issue. Moves to DRAIN once read DEPTH-1 has been issued.
  - DRAIN: waits for the FIFO to empty and the last handshake. Then moves to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- start is ignored outside IDLE, with no effect on the current run.
- A handshake occurs when out_valid && out_ready. out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0.
- Read issue rule: ram_rd_en=1 in STREAM when (fifo_count + inflight - pop) <= 1, where pop is this cycle's handshake. ram_addr increments by 1 per issued read. No wrap-around within a run; ram_addr returns to 0 in IDLE.
- Latency: if start is accepted at edge t, ram_rd_en/addr 0 appear in cycle t+1, and out_valid first rises in cycle t+3.
- With out_ready held high, the stream runs at one word per cycle: the last word is at cycle t+66 and the done pulse at t+67.
- The FIFO never overflows. A write and a pop in the same cycle keep the count unchanged.
- out_data is passed through unmodified; there is no sign extension or truncation (DATA_W in = DATA_W out).
- cycle_count increments every cycle busy=1, saturates at 2047, and holds its value after done until the next start.
- Reset asserted mid-run: returns to IDLE next edge with all outputs at reset values; a partially streamed matrix is abandoned.

Optional Feature:
Macro: RESULT_CHECKSUM_EN.
- Defined: adds output checksum[DATA_W+6-1:0] (signed, 25 bits). It is cleared on start accepted and accumulates the sign-extended out_data on every handshake. It is final and stable from the done pulse until the next start, and reset to 0.
- Undefined: no checksum port or logic.

Test Plan:
- RAM preloaded mem[i]=i-32, out_ready=1, start pulse -> 64 words, out_index 0..63 in order, out_data -32..31, out_last only on index 63, done exactly 1 cycle at start+67, cycle_count=66.
- Same RAM, out_ready low for 5 cycles after word 10 is presented -> word 10 (value -22, index 10) held stable, then stream resumes with no gap/duplicate; total handshakes=64.
- Random out_ready (50%), RAM of signed extremes (-262144, 262143 alternating) -> consumer sequence matches RAM exactly, ram_rd_en never issued with the FIFO full, no value corruption at the 19-bit limits.
- start re-pulsed at word 20 -> ignored, exactly 64 words, single done pulse.
- reset pulsed at word 30, then new start -> outputs at reset values the cycle after reset, then a fresh stream from index 0 with cycle_count restarted.
- RESULT_CHECKSUM_EN defined, mem[i]=i -> checksum=2016 at done; with mem all -262144 -> checksum=-16777216.
